// File: rtl/store_rmw_sequencer_if.sv
// Store request / data-memory bundle between the control FSM, the store
// sequencer and the single-port data memory.
interface store_rmw_sequencer_if;
   logic        start;
   logic [1:0]  store_size;
   logic [31:0] addr;
   logic [31:0] b_out;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;

   // Handshake: start is a request sampled only while busy is low; the
   // request is complete when done pulses for one cycle (err alongside it
   // for an illegal size). There is no back-pressure beyond busy.
   modport slave (
      input  start, store_size, addr, b_out, mem_rdata,
      output mem_addr, mem_wr, mem_wdata, busy, done, err
   );

   modport master (
      output start, store_size, addr, b_out, mem_rdata,
      input  mem_addr, mem_wr, mem_wdata, busy, done, err
   );
endinterface

// File: rtl/store_rmw_sequencer.sv
// Sequences word/half/byte stores to a single-port data memory; half and byte
// stores are done as read-merge-write of the low lane of the addressed word.
module store_rmw_sequencer #(
   parameter int MEM_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   store_rmw_sequencer_if.slave  bus,
   output logic [2:0]            dbg_state
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      state, state_n;
   logic [31:0] addr_q;
   logic [31:0] b_q;
   logic [1:0]  size_q;
   logic [31:0] rd_q;
   logic [CW-1:0] cnt;

   logic [31:0] mem_addr_c;
   logic        mem_wr_c;
   logic [31:0] mem_wdata_c;
   logic        busy_c;
   logic        done_c;
   logic        err_c;
   logic [31:0] keep;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         addr_q <= '0;
         b_q    <= '0;
         size_q <= '0;
         rd_q   <= '0;
         cnt    <= '0;
      end else begin
         state <= state_n;
         if (state == S_IDLE && bus.start) begin
            addr_q <= bus.addr;
            b_q    <= bus.b_out;
            size_q <= bus.store_size;
         end
         // cnt counts the remaining read-latency cycles spent in WAIT.
         if (state == S_READ)
            cnt <= CW'(MEM_LAT - 1);
         else if (state == S_WAIT && cnt != '0)
            cnt <= cnt - CW'(1);
         if (state == S_WAIT && cnt == '0)
            rd_q <= bus.mem_rdata;
      end
   end

   // Upper bits of the old word that survive a half or byte store.
   assign keep = (size_q == 2'b10) ? 32'hFFFF_0000 : 32'hFFFF_FF00;

   always_comb begin
      state_n     = state;
      mem_addr_c  = '0;
      mem_wr_c    = 1'b0;
      mem_wdata_c = '0;
      busy_c      = 1'b1;
      done_c      = 1'b0;
      err_c       = 1'b0;
      case (state)
         S_IDLE: begin
            busy_c = 1'b0;
            if (bus.start) begin
               case (bus.store_size)
                  2'b01:   state_n = S_WRITE;
                  2'b00:   state_n = S_DONE;
                  default: state_n = S_READ;
               endcase
            end
         end
         S_READ: begin
            mem_addr_c = addr_q;
            state_n    = S_WAIT;
         end
         S_WAIT: begin
            mem_addr_c = addr_q;
            if (cnt == '0) state_n = S_WRITE;
         end
         S_WRITE: begin
            mem_addr_c  = addr_q;
            mem_wr_c    = 1'b1;
            mem_wdata_c = (size_q == 2'b01) ? b_q : ((rd_q & keep) | (b_q & ~keep));
            state_n     = S_DONE;
         end
         S_DONE: begin
            done_c  = 1'b1;
            err_c   = (size_q == 2'b00);
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_wr    = mem_wr_c;
   assign bus.mem_wdata = mem_wdata_c;
   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.err       = err_c;
   assign dbg_state     = state;

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Bench for store_rmw_sequencer: two instances (read latency 1 and 3) share
// one stimulus stream; a cycle-level transaction model predicts every output.
module tb_store_rmw_sequencer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] b;

   store_rmw_sequencer_if if0 ();
   store_rmw_sequencer_if if1 ();

   assign if0.start = start;  assign if0.store_size = size;
   assign if0.addr  = addr;   assign if0.b_out      = b;
   assign if1.start = start;  assign if1.store_size = size;
   assign if1.addr  = addr;   assign if1.b_out      = b;

   logic [2:0] dbg0, dbg1;

   store_rmw_sequencer #(.MEM_LAT(1)) u0 (.clk(clk), .reset(reset), .bus(if0.slave), .dbg_state(dbg0));
   store_rmw_sequencer #(.MEM_LAT(3)) u1 (.clk(clk), .reset(reset), .bus(if1.slave), .dbg_state(dbg1));

   logic        o_wr[2], o_busy[2], o_done[2], o_err[2];
   logic [31:0] o_addr[2], o_wdata[2];
   assign o_wr[0] = if0.mem_wr;       assign o_wr[1] = if1.mem_wr;
   assign o_busy[0] = if0.busy;       assign o_busy[1] = if1.busy;
   assign o_done[0] = if0.done;       assign o_done[1] = if1.done;
   assign o_err[0] = if0.err;         assign o_err[1] = if1.err;
   assign o_addr[0] = if0.mem_addr;   assign o_addr[1] = if1.mem_addr;
   assign o_wdata[0] = if0.mem_wdata; assign o_wdata[1] = if1.mem_wdata;

   // Memory models: word index addr[5:2], read data delayed by the latency.
   logic [31:0] mem [2][16];
   logic [31:0] pipe [2][3];
   int cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
         if (o_wr[d] === 1'b1) mem[d][o_addr[d][5:2]] <= o_wdata[d];
         pipe[d][0] <= o_addr[d];
         pipe[d][1] <= pipe[d][0];
         pipe[d][2] <= pipe[d][1];
      end
   end

   assign if0.mem_rdata = mem[0][pipe[0][0][5:2]];
   assign if1.mem_rdata = mem[1][pipe[1][2][5:2]];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Reference model: one outstanding store per instance, tracked by cycle numbers.
   bit          act[2];
   int          acc_c[2], wr_c[2], dn_c[2];
   logic [1:0]  m_sz[2];
   logic [31:0] m_ad[2], m_b[2];
   logic [31:0] ref_mem [2][16];
   bit          chk_en = 1'b0;

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            automatic int n = cyc;
            automatic bit inop = act[d] && (n > acc_c[d]) && (n <= dn_c[d]);
            automatic logic [31:0] wd;
            automatic logic [31:0] old;
            if (inop) begin
               chk($sformatf("d%0d_busy", d), 32'(o_busy[d]), 32'd1);
               if (n == dn_c[d]) begin
                  chk($sformatf("d%0d_done", d), 32'(o_done[d]), 32'd1);
                  chk($sformatf("d%0d_err", d), 32'(o_err[d]), 32'(m_sz[d] == 2'b00));
                  chk($sformatf("d%0d_wr_done", d), 32'(o_wr[d]), 32'd0);
                  chk($sformatf("d%0d_addr_done", d), o_addr[d], 32'd0);
                  chk($sformatf("d%0d_wdata_done", d), o_wdata[d], 32'd0);
               end else begin
                  chk($sformatf("d%0d_done_mid", d), 32'(o_done[d]), 32'd0);
                  chk($sformatf("d%0d_err_mid", d), 32'(o_err[d]), 32'd0);
                  chk($sformatf("d%0d_addr", d), o_addr[d], m_ad[d]);
                  chk($sformatf("d%0d_wr", d), 32'(o_wr[d]), 32'(n == wr_c[d]));
                  if (n == wr_c[d]) begin
                     old = ref_mem[d][m_ad[d][5:2]];
                     case (m_sz[d])
                        2'b01:   wd = m_b[d];
                        2'b10:   wd = {old[31:16], m_b[d][15:0]};
                        default: wd = {old[31:8], m_b[d][7:0]};
                     endcase
                     chk($sformatf("d%0d_wdata", d), o_wdata[d], wd);
                     ref_mem[d][m_ad[d][5:2]] = wd;
                  end
               end
            end else begin
               chk($sformatf("d%0d_busy_idle", d), 32'(o_busy[d]), 32'd0);
               chk($sformatf("d%0d_done_idle", d), 32'(o_done[d]), 32'd0);
               chk($sformatf("d%0d_err_idle", d), 32'(o_err[d]), 32'd0);
               chk($sformatf("d%0d_wr_idle", d), 32'(o_wr[d]), 32'd0);
               chk($sformatf("d%0d_addr_idle", d), o_addr[d], 32'd0);
               chk($sformatf("d%0d_wdata_idle", d), o_wdata[d], 32'd0);
            end
            if (start && !inop) begin
               act[d]   = 1'b1;
               acc_c[d] = n;
               m_sz[d]  = size;
               m_ad[d]  = addr;
               m_b[d]   = b;
               case (size)
                  2'b00: begin wr_c[d] = -1;             dn_c[d] = n + 1; end
                  2'b01: begin wr_c[d] = n + 1;          dn_c[d] = n + 2; end
                  default: begin wr_c[d] = n + 2 + lat(d); dn_c[d] = n + 3 + lat(d); end
               endcase
            end
         end
      end
   end

   task automatic drive(input bit st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] bb);
      @(posedge clk);
      #1;
      start = st;
      size  = sz;
      addr  = a;
      b     = bb;
   endtask

   task automatic idle(input int k);
      repeat (k) drive(1'b0, 2'($urandom), $urandom, $urandom);
   endtask

   task automatic chk_quiet(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_d%0d_wr", tag, d), 32'(o_wr[d]), 32'd0);
         chk($sformatf("%s_d%0d_busy", tag, d), 32'(o_busy[d]), 32'd0);
         chk($sformatf("%s_d%0d_done", tag, d), 32'(o_done[d]), 32'd0);
         chk($sformatf("%s_d%0d_err", tag, d), 32'(o_err[d]), 32'd0);
         chk($sformatf("%s_d%0d_addr", tag, d), o_addr[d], 32'd0);
         chk($sformatf("%s_d%0d_wdata", tag, d), o_wdata[d], 32'd0);
      end
   endtask

   initial begin
      start = 1'b0; size = 2'b00; addr = '0; b = '0;
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         automatic logic [31:0] v = $urandom;
         if (i == 8 || i == 9) v = 32'h1122_3344;
         for (int d = 0; d < 2; d++) begin
            mem[d][i]     = v;
            ref_mem[d][i] = v;
         end
      end
      for (int d = 0; d < 2; d++) begin
         act[d] = 1'b0;
         for (int j = 0; j < 3; j++) pipe[d][j] = '0;
      end

      repeat (2) @(posedge clk);
      #1;
      chk_quiet("reset");
      reset  = 1'b1;
      chk_en = 1'b1;

      // Directed word, half, byte and illegal stores.
      drive(1'b1, 2'b01, 32'h10, 32'hDEAD_BEEF);
      idle(6);
      drive(1'b1, 2'b10, 32'h20, 32'hAAAA_BBBB);
      idle(10);
      chk("sh_mem_d0", mem[0][8], 32'h1122_BBBB);
      chk("sh_mem_d1", mem[1][8], 32'h1122_BBBB);
      drive(1'b1, 2'b11, 32'h24, 32'h0000_00CC);
      idle(10);
      chk("sb_mem_d0", mem[0][9], 32'h1122_33CC);
      chk("sb_mem_d1", mem[1][9], 32'h1122_33CC);
      drive(1'b1, 2'b00, 32'h2C, 32'h1234_5678);
      idle(4);

      // Start held high with changing inputs: only the cycle after DONE accepts.
      drive(1'b1, 2'b10, 32'h28, 32'h0F0F_0F0F);
      repeat (14) drive(1'b1, 2'($urandom_range(1, 3)), $urandom, $urandom);
      idle(10);

      // Reset asserted while the word store is writing.
      drive(1'b1, 2'b01, 32'h30, 32'h55AA_55AA);
      @(posedge clk);
      #1;
      start = 1'b0;
      #1;
      chk("pre_rst_wr_d0", 32'(o_wr[0]), 32'd1);
      chk("pre_rst_wr_d1", 32'(o_wr[1]), 32'd1);
      chk_en = 1'b0;
      reset  = 1'b0;
      #1;
      chk_quiet("rst_mid");
      repeat (2) @(posedge clk);
      #1;
      chk_quiet("rst_hold");
      reset = 1'b1;
      for (int d = 0; d < 2; d++) act[d] = 1'b0;
      chk_en = 1'b1;
      idle(3);

      // Random traffic.
      for (int i = 0; i < 1500; i++)
         drive($urandom_range(0, 3) == 0, 2'($urandom), $urandom, $urandom);
      idle(12);

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++)
            chk($sformatf("final_mem_d%0d_%0d", d, i), mem[d][i], ref_mem[d][i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
